pipeline_hazard_controller: RTL and testbench

- Central stall/bubble sequencer for the 5-stage in-order pipeline (IF, ID, EX, MA, WB).
- Observes the ID, EX and MA stages and decides each cycle which pipeline registers hold and which load a bubble:
  - Decode, Execute, MemoryAccess and WriteBack stage registers;
  - PC redirect.
- Handles data-memory wait, multi-cycle mul/div, branch-mispredict flush and load-use interlock.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_controller.sv | 94 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/bubble/redirect sequencer for the 5-stage in-order pipeline
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_id_*                            ID-stage valid flag and source-register usage
//   i_ex_*                            EX-stage valid, destination, load/mispredict/muldiv flags
//   i_muldiv_done                     mul/div result valid this cycle
//   i_ma_mem_req, i_ma_mem_ack        MA-stage data-memory request and completion
//   o_pc/de/ex/ma_stall               hold PC / stage registers
//   o_de/ex/ma/wb_bubble              load a bubble into stage registers
//   o_pc_redirect                     take the EX-computed target as next PC
//   o_stall_cycles                    saturating count of PC-stall cycles
//   o_mem_timeout                     sticky: memory wait exceeded MEM_TIMEOUT
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_id_valid,
    input  logic [4:0]           i_id_rs1_addr,
    input  logic [4:0]           i_id_rs2_addr,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic                 i_ex_valid,
    input  logic [4:0]           i_ex_rd_addr,
    input  logic                 i_ex_is_load,
    input  logic                 i_ex_mispredict,
    input  logic                 i_ex_muldiv_start,
    input  logic                 i_muldiv_done,
    input  logic                 i_ma_mem_req,
    input  logic                 i_ma_mem_ack,
    output logic                 o_pc_stall,
    output logic                 o_de_stall,
    output logic                 o_ex_stall,
    output logic                 o_ma_stall,
    output logic                 o_de_bubble,
    output logic                 o_ex_bubble,
    output logic                 o_ma_bubble,
    output logic                 o_wb_bubble,
    output logic                 o_pc_redirect,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic                 o_mem_timeout
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT} state_t;
    state_t r_state, w_next;
    logic [WW-1:0] r_wait, w_wait_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic r_timeout;
    logic w_mem, w_md, w_mp, w_lu, w_mem_act, w_md_act, w_mp_act, w_lu_act;
    always_comb begin
        w_mem = i_ma_mem_req & !i_ma_mem_ack;
        w_md  = (r_state == MD_WAIT | i_ex_muldiv_start) & !i_muldiv_done;
        w_mp  = i_ex_valid & i_ex_mispredict;
        w_lu  = i_ex_valid & i_ex_is_load & (i_ex_rd_addr != 5'd0) & i_id_valid &
                ((i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr)) |
                 (i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr)));
        // only the highest-priority active condition drives the outputs; reset silences all
        w_mem_act = !i_rst & w_mem;
        w_md_act  = !i_rst & !w_mem & w_md;
        w_mp_act  = !i_rst & !w_mem & !w_md & w_mp;
        w_lu_act  = !i_rst & !w_mem & !w_md & !w_mp & w_lu;
        o_pc_stall    = w_mem_act | w_md_act | w_lu_act;
        o_de_stall    = w_mem_act | w_md_act | w_lu_act;
        o_ex_stall    = w_mem_act | w_md_act;
        o_ma_stall    = w_mem_act;
        o_de_bubble   = w_mp_act;
        o_ex_bubble   = w_mp_act | w_lu_act;
        o_ma_bubble   = w_md_act;
        o_wb_bubble   = w_mem_act;
        o_pc_redirect = w_mp_act;
        // a muldiv waiting in EX during the ack cycle goes straight to MD_WAIT
        w_next = (r_state == RUN)      ? (w_mem ? MEM_WAIT : (w_md ? MD_WAIT : RUN)) :
                 (r_state == MEM_WAIT) ? (i_ma_mem_ack ? (w_md ? MD_WAIT : RUN) : MEM_WAIT) :
                                         (i_muldiv_done ? RUN : MD_WAIT);
        w_wait_nxt = (r_state == MEM_WAIT && !i_ma_mem_ack) ?
                     ((r_wait == WW'(MEM_TIMEOUT)) ? r_wait : r_wait + 1'b1) : '0;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= RUN;
            r_wait         <= '0;
            r_stall_cycles <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_wait         <= w_wait_nxt;
            r_stall_cycles <= (o_pc_stall && !(&r_stall_cycles)) ? r_stall_cycles + 1'b1 : r_stall_cycles;
            r_timeout      <= r_timeout | (w_wait_nxt == WW'(MEM_TIMEOUT));
        end
    end
    assign o_stall_cycles = r_stall_cycles;
    assign o_mem_timeout  = r_timeout;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: table vectors, hand sequences and random run against a reference model
module tb_pipeline_hazard_controller;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [8:0] P_MEM = 9'b1111_0001_0;
    localparam logic [8:0] P_MD  = 9'b1110_0010_0;
    localparam logic [8:0] P_MP  = 9'b0000_1100_1;
    localparam logic [8:0] P_LU  = 9'b1100_0100_0;
    localparam logic [8:0] P_0   = 9'b0;

    typedef struct packed {
        logic idv; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
        logic exv; logic [4:0] rd; logic ld; logic mis; logic st; logic done;
        logic req; logic ack;
    } stim_t;
    typedef struct { string name; stim_t s; logic [8:0] exp; } vec_t;

    logic clk = 0, rst = 1;
    logic id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, ex_mispredict;
    logic ex_muldiv_start, muldiv_done, ma_mem_req, ma_mem_ack;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic pc_stall, de_stall, ex_stall, ma_stall, de_bubble, ex_bubble, ma_bubble, wb_bubble, pc_redirect;
    logic [CW-1:0] stall_cycles;
    logic mem_timeout;
    int n_vec = 0, n_err = 0;
    bit m_md, m_memw, m_to;
    int m_wait, m_stall;
    vec_t tbl[$];

    pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs1_addr(id_rs1_addr),
        .i_id_rs2_addr(id_rs2_addr), .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_ex_valid(ex_valid), .i_ex_rd_addr(ex_rd_addr), .i_ex_is_load(ex_is_load),
        .i_ex_mispredict(ex_mispredict), .i_ex_muldiv_start(ex_muldiv_start),
        .i_muldiv_done(muldiv_done), .i_ma_mem_req(ma_mem_req), .i_ma_mem_ack(ma_mem_ack),
        .o_pc_stall(pc_stall), .o_de_stall(de_stall), .o_ex_stall(ex_stall), .o_ma_stall(ma_stall),
        .o_de_bubble(de_bubble), .o_ex_bubble(ex_bubble), .o_ma_bubble(ma_bubble),
        .o_wb_bubble(wb_bubble), .o_pc_redirect(pc_redirect), .o_stall_cycles(stall_cycles),
        .o_mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [8:0] outs();
        return {pc_stall, de_stall, ex_stall, ma_stall, de_bubble, ex_bubble, ma_bubble, wb_bubble, pc_redirect};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        id_valid = s.idv; id_rs1_addr = s.rs1; id_rs2_addr = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_valid = s.exv; ex_rd_addr = s.rd;
        ex_is_load = s.ld; ex_mispredict = s.mis; ex_muldiv_start = s.st;
        muldiv_done = s.done; ma_mem_req = s.req; ma_mem_ack = s.ack;
    endtask

    function automatic logic [8:0] model_out(stim_t s);
        bit mem = s.req & !s.ack;
        bit md  = (m_md | s.st) & !s.done;
        bit mp  = s.exv & s.mis;
        bit lu  = s.exv & s.ld & (s.rd != 0) & s.idv &
                  ((s.u1 & (s.rs1 == s.rd)) | (s.u2 & (s.rs2 == s.rd)));
        return mem ? P_MEM : md ? P_MD : mp ? P_MP : lu ? P_LU : P_0;
    endfunction

    task automatic model_update(input stim_t s);
        logic [8:0] o = model_out(s);
        bit mem = s.req & !s.ack;
        bit md  = (m_md | s.st) & !s.done;
        if (o[8] && m_stall < (1 << CW) - 1) m_stall++;
        if (m_memw) begin
            if (s.ack) begin m_memw = 0; m_wait = 0; m_md = md; end
            else begin
                if (m_wait < TO) m_wait++;
                if (m_wait == TO) m_to = 1;
            end
        end else if (m_md) begin
            if (s.done) m_md = 0;
        end else if (mem) m_memw = 1;
        else if (md) m_md = 1;
    endtask

    task automatic model_reset();
        m_md = 0; m_memw = 0; m_to = 0; m_wait = 0; m_stall = 0;
    endtask

    task automatic cyc(input stim_t s, input string nm, input logic [8:0] exp);
        @(negedge clk);
        drive(s);
        #1;
        chk(nm, int'(outs()), int'(exp));
        chk({nm, "_cnt"}, int'(stall_cycles), m_stall);
        chk({nm, "_to"}, int'(mem_timeout), int'(m_to));
        @(posedge clk);
        model_update(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        drive('0);
        #1;
        chk("rst_outs", int'(outs()), 0);
        model_reset();
        @(negedge clk);
        chk("rst_cnt", int'(stall_cycles), 0);
        chk("rst_to", int'(mem_timeout), 0);
        rst = 0;
    endtask

    task automatic add(input string nm, input stim_t s, input logic [8:0] exp);
        vec_t v;
        v.name = nm; v.s = s; v.exp = exp;
        tbl.push_back(v);
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.idv = 1'($urandom_range(1)); s.rs1 = 5'($urandom_range(3)); s.rs2 = 5'($urandom_range(3));
        s.u1 = 1'($urandom_range(1)); s.u2 = 1'($urandom_range(1)); s.exv = 1'($urandom_range(1));
        s.rd = 5'($urandom_range(3)); s.ld = 1'($urandom_range(1));
        s.mis = ($urandom_range(3) == 0); s.st = ($urandom_range(4) == 0);
        s.done = ($urandom_range(2) == 0); s.req = ($urandom_range(2) == 0);
        s.ack = ($urandom_range(1) == 0);
        return s;
    endfunction

    initial begin
        stim_t s, lu;
        drive('0);
        model_reset();
        lu = '0; lu.idv = 1; lu.rs1 = 5'd3; lu.rs2 = 5'd5; lu.u1 = 1; lu.u2 = 1; lu.exv = 1; lu.rd = 5'd5; lu.ld = 1;
        add("idle", '0, P_0);
        add("lu_rs2", lu, P_LU);
        s = lu; s.rs1 = 5'd5; s.rs2 = 5'd3; s.u2 = 0; add("lu_rs1", s, P_LU);
        s = lu; s.rd = 5'd0; s.rs1 = 5'd0; s.rs2 = 5'd0; add("lu_rd0", s, P_0);
        s = lu; s.u1 = 0; s.u2 = 0; add("lu_unused", s, P_0);
        s = lu; s.idv = 0; add("lu_idinv", s, P_0);
        s = lu; s.exv = 0; add("lu_exinv", s, P_0);
        s = lu; s.ld = 0; add("lu_noload", s, P_0);
        s = '0; s.exv = 1; s.mis = 1; add("mp", s, P_MP);
        s = lu; s.mis = 1; add("mp_over_lu", s, P_MP);
        s = '0; s.mis = 1; add("mp_exinv", s, P_0);
        s = '0; s.req = 1; add("mem", s, P_MEM);
        s = '0; s.req = 1; s.ack = 1; add("mem_ack", s, P_0);
        s = '0; s.st = 1; add("md", s, P_MD);
        s = '0; s.st = 1; s.done = 1; add("md_done", s, P_0);
        s = '0; s.exv = 1; s.mis = 1; s.st = 1; s.req = 1; add("mem_over_md_mp", s, P_MEM);
        s = '0; s.exv = 1; s.mis = 1; s.st = 1; add("md_over_mp", s, P_MD);
        s = lu; s.st = 1; add("md_over_lu", s, P_MD);
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].name, tbl[i].exp);
            do_reset();
        end

        cyc(lu, "seq_lu", P_LU);
        cyc('0, "seq_lu_after", P_0);
        chk("seq_lu_cnt", int'(stall_cycles), 1);

        do_reset();
        s = '0; s.req = 1;
        for (int i = 0; i < 3; i++) cyc(s, "seq_mem", P_MEM);
        s.ack = 1;
        cyc(s, "seq_mem_ack", P_0);
        cyc('0, "seq_mem_after", P_0);
        chk("seq_mem_cnt", int'(stall_cycles), 3);

        do_reset();
        s = '0; s.exv = 1; s.mis = 1; s.st = 1;
        cyc(s, "seq_md1", P_MD);
        s.req = 1;
        cyc(s, "seq_md_mem2", P_MEM);
        cyc(s, "seq_md_mem3", P_MEM);
        s.req = 0;
        cyc(s, "seq_md4", P_MD);
        cyc(s, "seq_md5", P_MD);
        s.done = 1;
        cyc(s, "seq_md_done_mp", P_MP);
        cyc('0, "seq_md_after", P_0);

        do_reset();
        s = '0; s.req = 1;
        for (int i = 0; i < 3; i++) cyc(s, "seq_to_wait", P_MEM);
        #1;
        chk("seq_to_early", int'(mem_timeout), 0);
        for (int i = 0; i < 3; i++) cyc(s, "seq_to_wait", P_MEM);
        #1;
        chk("seq_to_set", int'(mem_timeout), 1);
        s.ack = 1;
        cyc(s, "seq_to_ack", P_0);
        #1;
        chk("seq_to_sticky", int'(mem_timeout), 1);
        s = '0; s.st = 1;
        cyc(s, "seq_to_md", P_MD);
        cyc(s, "seq_to_md", P_MD);
        @(negedge clk);
        drive(s);
        rst = 1;
        #1;
        chk("seq_rst_outs", int'(outs()), 0);
        chk("seq_rst_cnt", int'(stall_cycles), 0);
        chk("seq_rst_to", int'(mem_timeout), 0);
        model_reset();
        @(negedge clk);
        drive('0);
        rst = 0;

        s = '0; s.req = 1;
        for (int i = 0; i < 20; i++) cyc(s, "seq_sat", P_MEM);
        s.ack = 1;
        cyc(s, "seq_sat_ack", P_0);
        #1;
        chk("seq_sat_cnt", int'(stall_cycles), 15);

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            s = rnd();
            cyc(s, "rnd", model_out(s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
